// File: rtl/m_store_buffer_pkg.sv
// Shared store-buffer definitions: default depth, entry field widths and the
// packed layout of one buffered store.
package m_store_buffer_pkg;

  localparam int SB_DEPTH_DEF = 4;
  localparam int SB_ADDR_W    = 30;
  localparam int SB_BE_W      = 4;
  localparam int SB_DATA_W    = 32;
  localparam int SB_PC_W      = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_BE_W-1:0]   be;
    logic [SB_DATA_W-1:0] data;
    logic [SB_PC_W-1:0]   pc;
  } sb_entry_t;

endpackage

// File: rtl/m_store_buffer_fwd.sv
// One byte lane of load forwarding: picks the youngest matching entry from an
// age-ordered match vector (bit 0 = oldest).
module m_sb_fwd
  import m_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF
) (
  input  logic [DEPTH-1:0]   match,
  input  logic [DEPTH*8-1:0] lane_bytes,
  output logic               hit,
  output logic [7:0]         data
);

  // Later (younger) matches override earlier ones; data stays 0 without a hit.
  always_comb begin
    hit  = |match;
    data = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) begin
        data = lane_bytes[i*8 +: 8];
      end else begin
        data = data;
      end
    end
  end

endmodule

// File: rtl/m_store_buffer.sv
// In-order store buffer between the M stage and data memory, with per-byte
// load forwarding from every pending entry.
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [3:0]               st_be,
  input  logic [31:0]              st_data,
  input  logic [31:0]              st_pc,
  output logic                     st_ready,
  input  logic [31:0]              ld_addr,
  output logic [3:0]               ld_hit,
  output logic [31:0]              ld_fwd_data,
  input  logic                     dm_busy,
  output logic                     dm_we,
  output logic [31:0]              dm_addr,
  output logic [3:0]               dm_be,
  output logic [31:0]              dm_wd,
  output logic [31:0]              dm_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  sb_entry_t          mem_r [DEPTH];
  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [CNT_W-1:0]   count_r;
  logic               ovf_r;

  logic               empty_s;
  logic               st_ready_s;
  logic               push_s;
  logic               drop_s;
  logic               pop_s;
  sb_entry_t          head_s;
  logic [PTR_W-1:0]   idx_s;
  logic [DEPTH-1:0]   match_s [4];
  logic [DEPTH*8-1:0] lane_s [4];
  logic               unused_s;

  // Byte selection lives entirely in the enables, so word-offset bits are dead.
  assign unused_s   = ^{st_addr[1:0], ld_addr[1:0]};

  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign st_ready_s = reset & (count_r < DEPTH_C);
  assign push_s     = st_valid & st_ready_s & (st_be != 4'h0);
  assign drop_s     = st_valid & ~st_ready_s & (st_be != 4'h0);
  assign pop_s      = reset & ~empty_s & ~dm_busy;
  assign head_s     = mem_r[head_r];

  assign st_ready   = st_ready_s;
  assign dm_we      = pop_s;
  assign count      = count_r;
  assign empty      = empty_s;
  assign ovf        = ovf_r;

  // Drain port mirrors the head entry and is forced to zero when nothing is queued.
  always_comb begin
    dm_addr = 32'h0;
    dm_be   = 4'h0;
    dm_wd   = 32'h0;
    dm_pc   = 32'h0;
    if (!empty_s) begin
      dm_addr = {head_s.addr, 2'b00};
      dm_be   = head_s.be;
      dm_wd   = head_s.data;
      dm_pc   = head_s.pc;
    end else begin
      dm_addr = 32'h0;
    end
  end

  // Age-ordered view of the ring: position i is the i-th oldest valid entry.
  always_comb begin
    idx_s = {PTR_W{1'b0}};
    for (int b = 0; b < 4; b++) begin
      match_s[b] = {DEPTH{1'b0}};
      lane_s[b]  = {(DEPTH*8){1'b0}};
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_r + PTR_W'(i);
      for (int b = 0; b < 4; b++) begin
        match_s[b][i]      = reset && (CNT_W'(i) < count_r) &&
                             (mem_r[idx_s].addr == ld_addr[31:2]) && mem_r[idx_s].be[b];
        lane_s[b][i*8 +: 8] = mem_r[idx_s].data[b*8 +: 8];
      end
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_fwd
    m_sb_fwd #(.DEPTH(DEPTH)) u_fwd (
      .match      (match_s[b]),
      .lane_bytes (lane_s[b]),
      .hit        (ld_hit[b]),
      .data       (ld_fwd_data[b*8 +: 8])
    );
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      if (push_s) tail_r <= tail_r + PTR_W'(1);
      if (pop_s)  head_r <= head_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) ovf_r <= 1'b1;
    end
  end

  // Entry storage; validity is tracked by count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[tail_r] <= '{addr: st_addr[31:2], be: st_be, data: st_data, pc: st_pc};
    end
  end

endmodule

// File: tb/tb_m_store_buffer.sv
// Directed self-checking bench for m_store_buffer (DEPTH=4).
module tb_m_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic [3:0]  ld_hit;
  logic [31:0] ld_fwd_data;
  logic        dm_busy;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [2:0]  count;
  logic        empty;
  logic        ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  m_store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_be(st_be), .st_data(st_data), .st_pc(st_pc),
    .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data),
    .dm_busy(dm_busy),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wd(dm_wd), .dm_pc(dm_pc),
    .count(count), .empty(empty), .ovf(ovf)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    st_valid = v;
    st_addr  = a;
    st_be    = be;
    st_data  = d;
    st_pc    = a + 32'h1000;
  endtask

  task automatic test_reset();
    reset = 1'b0; dm_busy = 1'b0; ld_addr = 32'h10;
    put(1'b0, 32'h0, 4'h0, 32'h0);
    cyc(); cyc();
    put(1'b1, 32'h10, 4'hF, 32'h12345678);
    #1;
    n_cmp++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL rst_dm_we got %b exp 0", dm_we); end
    n_cmp++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL rst_st_ready got %b exp 0", st_ready); end
    n_cmp++; if (ld_hit !== 4'h0) begin n_fail++; $display("FAIL rst_ld_hit got %h exp 0", ld_hit); end
    cyc();
    reset = 1'b1;
    put(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL post_rst_empty got %b exp 1", empty); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL post_rst_count got %0d exp 0", count); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL post_rst_ovf got %b exp 0", ovf); end
    n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_st_ready got %b exp 1", st_ready); end
    n_cmp++; if ({dm_we, dm_addr, dm_be, dm_wd, dm_pc} !== 101'h0) begin
      n_fail++; $display("FAIL post_rst_dm got we=%b addr=%h be=%h wd=%h pc=%h exp all 0", dm_we, dm_addr, dm_be, dm_wd, dm_pc);
    end
  endtask

  task automatic test_single();
    put(1'b1, 32'h10, 4'h0, 32'hDEAD0000);
    cyc();
    put(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL be0_discard_count got %0d exp 0", count); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL be0_discard_ovf got %b exp 0", ovf); end
    put(1'b1, 32'h13, 4'hF, 32'h11223344);
    ld_addr = 32'h10;
    #1;
    n_cmp++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL single_same_cycle_we got %b exp 0", dm_we); end
    n_cmp++; if (ld_hit !== 4'h0) begin n_fail++; $display("FAIL single_st_excluded got %h exp 0", ld_hit); end
    cyc();
    put(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (dm_we !== 1'b1) begin n_fail++; $display("FAIL single_we got %b exp 1", dm_we); end
    n_cmp++; if (dm_addr !== 32'h10) begin n_fail++; $display("FAIL single_addr got %h exp 00000010", dm_addr); end
    n_cmp++; if (dm_wd !== 32'h11223344) begin n_fail++; $display("FAIL single_wd got %h exp 11223344", dm_wd); end
    n_cmp++; if (dm_be !== 4'hF) begin n_fail++; $display("FAIL single_be got %h exp f", dm_be); end
    n_cmp++; if (dm_pc !== 32'h1013) begin n_fail++; $display("FAIL single_pc got %h exp 00001013", dm_pc); end
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", count); end
    n_cmp++; if (ld_hit !== 4'hF) begin n_fail++; $display("FAIL head_drain_hit got %h exp f", ld_hit); end
    n_cmp++; if (ld_fwd_data !== 32'h11223344) begin n_fail++; $display("FAIL head_drain_fwd got %h exp 11223344", ld_fwd_data); end
    cyc();
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got %b exp 1", empty); end
    n_cmp++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL single_we_after got %b exp 0", dm_we); end
    n_cmp++; if (dm_addr !== 32'h0) begin n_fail++; $display("FAIL single_addr_empty got %h exp 0", dm_addr); end
    n_cmp++; if (ld_hit !== 4'h0) begin n_fail++; $display("FAIL single_hit_empty got %h exp 0", ld_hit); end
  endtask

  task automatic test_overflow();
    logic exp_rdy;
    dm_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      put(1'b1, 32'h40 + 32'(k * 4), 4'hF, 32'hA0000000 + 32'(k));
      #1;
      exp_rdy = (k < 4);
      n_cmp++; if (st_ready !== exp_rdy) begin n_fail++; $display("FAIL ovf_st_ready[%0d] got %b exp %b", k, st_ready, exp_rdy); end
      cyc();
    end
    put(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d exp 4", count); end
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", ovf); end
    n_cmp++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_we got %b exp 0", dm_we); end
    dm_busy = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (dm_we !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_we[%0d] got %b exp 1", k, dm_we); end
      n_cmp++; if (dm_addr !== 32'h40 + 32'(k * 4)) begin
        n_fail++; $display("FAIL ovf_drain_addr[%0d] got %h exp %h", k, dm_addr, 32'h40 + 32'(k * 4));
      end
      n_cmp++; if (dm_wd !== 32'hA0000000 + 32'(k)) begin
        n_fail++; $display("FAIL ovf_drain_wd[%0d] got %h exp %h", k, dm_wd, 32'hA0000000 + 32'(k));
      end
      cyc();
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_empty got %b exp 1", empty); end
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
  endtask

  task automatic test_forward();
    dm_busy = 1'b1;
    put(1'b1, 32'h20, 4'h1, 32'h000000AA);
    cyc();
    put(1'b1, 32'h20, 4'h3, 32'h0000BBCC);
    cyc();
    put(1'b0, 32'h0, 4'h0, 32'h0);
    ld_addr = 32'h23;
    #1;
    n_cmp++; if (ld_hit !== 4'b0011) begin n_fail++; $display("FAIL fwd_hit got %b exp 0011", ld_hit); end
    n_cmp++; if (ld_fwd_data !== 32'h0000BBCC) begin n_fail++; $display("FAIL fwd_data got %h exp 0000bbcc", ld_fwd_data); end
    ld_addr = 32'h24;
    #1;
    n_cmp++; if (ld_hit !== 4'h0) begin n_fail++; $display("FAIL fwd_miss_hit got %b exp 0000", ld_hit); end
    n_cmp++; if (ld_fwd_data !== 32'h0) begin n_fail++; $display("FAIL fwd_miss_data got %h exp 0", ld_fwd_data); end
    put(1'b1, 32'h21, 4'hC, 32'h99880000);
    ld_addr = 32'h20;
    #1;
    n_cmp++; if (ld_hit !== 4'b0011) begin n_fail++; $display("FAIL fwd_excl_hit got %b exp 0011", ld_hit); end
    cyc();
    put(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (ld_hit !== 4'hF) begin n_fail++; $display("FAIL fwd_merge_hit got %b exp 1111", ld_hit); end
    n_cmp++; if (ld_fwd_data !== 32'h9988BBCC) begin n_fail++; $display("FAIL fwd_merge_data got %h exp 9988bbcc", ld_fwd_data); end
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL fwd_count got %0d exp 3", count); end
  endtask

  task automatic test_reset_mid();
    dm_busy = 1'b0;
    reset   = 1'b0;
    ld_addr = 32'h20;
    #1;
    n_cmp++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_we got %b exp 0", dm_we); end
    n_cmp++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready got %b exp 0", st_ready); end
    n_cmp++; if (ld_hit !== 4'h0) begin n_fail++; $display("FAIL mid_rst_hit got %b exp 0", ld_hit); end
    cyc();
    reset = 1'b1;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_rst_count got %0d exp 0", count); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf got %b exp 0", ovf); end
    n_cmp++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_we_after got %b exp 0", dm_we); end
    cyc();
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty got %b exp 1", empty); end
  endtask

  task automatic test_full_drain();
    logic [31:0] exp_a [3];
    logic [31:0] exp_d [3];
    exp_a = '{32'h68, 32'h6C, 32'h70};
    exp_d = '{32'h62, 32'h63, 32'h77777777};
    dm_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      put(1'b1, 32'h60 + 32'(k * 4), 4'hF, 32'h60 + 32'(k));
      cyc();
    end
    dm_busy = 1'b0;
    put(1'b1, 32'h70, 4'hF, 32'h77777777);
    #1;
    n_cmp++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", st_ready); end
    n_cmp++; if (dm_we !== 1'b1) begin n_fail++; $display("FAIL full_we got %b exp 1", dm_we); end
    n_cmp++; if (dm_addr !== 32'h60) begin n_fail++; $display("FAIL full_addr got %h exp 00000060", dm_addr); end
    cyc();
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_count got %0d exp 3", count); end
    n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_next got %b exp 1", st_ready); end
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL full_ovf got %b exp 1", ovf); end
    cyc();
    put(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pushpop_count got %0d exp 3", count); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (dm_addr !== exp_a[k] || dm_wd !== exp_d[k] || dm_we !== 1'b1) begin
        n_fail++; $display("FAIL full_drain[%0d] got we=%b addr=%h wd=%h exp we=1 addr=%h wd=%h", k, dm_we, dm_addr, dm_wd, exp_a[k], exp_d[k]);
      end
      cyc();
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_empty got %b exp 1", empty); end
  endtask

  task automatic test_random();
    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    logic        exp_rdy;
    logic        exp_we;
    logic [3:0]  be;
    int          accepted = 0;
    int          written  = 0;
    reset = 1'b0;
    cyc();
    reset   = 1'b1;
    ld_addr = 32'h0;
    for (int i = 0; i < 48; i++) begin
      dm_busy = (i < 40) ? ($urandom_range(0, 2) == 0) : 1'b0;
      be      = (i % 7 == 3) ? 4'h0 : 4'hF;
      put(i < 40, 32'h200 + 32'(i * 4), be, $urandom);
      #1;
      exp_rdy = (q_addr.size() < 4);
      exp_we  = (q_addr.size() > 0) && !dm_busy;
      n_cmp++; if (st_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, st_ready, exp_rdy); end
      n_cmp++; if (dm_we !== exp_we) begin n_fail++; $display("FAIL rnd_we[%0d] got %b exp %b", i, dm_we, exp_we); end
      if (exp_we) begin
        n_cmp++; if (dm_addr !== q_addr[0] || dm_wd !== q_data[0]) begin
          n_fail++; $display("FAIL rnd_write[%0d] got addr=%h wd=%h exp addr=%h wd=%h", i, dm_addr, dm_wd, q_addr[0], q_data[0]);
        end
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
        written++;
      end
      if (st_valid && exp_rdy && be != 4'h0) begin
        q_addr.push_back(st_addr);
        q_data.push_back(st_data);
        accepted++;
      end
      cyc();
    end
    put(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (written !== accepted) begin n_fail++; $display("FAIL rnd_total got %0d writes exp %0d", written, accepted); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rnd_final_count got %0d exp 0", count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_forward();
    test_reset_mid();
    test_full_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/m_store_buffer.md
M_STORE_BUFFER -- requirements
Module: m_store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffered store entries (a power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-004 The block SHALL have ports st_valid in 1, st_addr in 32, st_be in 4, st_data in 32 and st_pc in 32: a store request from the M stage (address, byte enables, byte-lane-aligned data, PC).
REQ-005 The block SHALL have port st_ready, output, 1 bit: the buffer can accept a store this cycle.
REQ-006 The block SHALL have ports ld_addr in 32, ld_hit out 4 and ld_fwd_data out 32: the load lookup address, per-byte forward hit, and forwarded bytes.
REQ-007 The block SHALL have port dm_busy, input, 1 bit: the DM port is unavailable this cycle.
REQ-008 The block SHALL have ports dm_we out 1, dm_addr out 32, dm_be out 4, dm_wd out 32 and dm_pc out 32: the drain write toward data memory.
REQ-009 The block SHALL have ports count out clog2(DEPTH)+1, empty out 1 and ovf out 1: occupancy, empty flag, and sticky overflow flag.

Function
REQ-010 The block SHALL implement an in-order FIFO of DEPTH entries; each entry holds {addr[31:2], be, data, pc}.
REQ-011 The block SHALL drive st_ready = (count < DEPTH); st_ready SHALL NOT depend on a same-cycle drain.
REQ-012 The block SHALL enqueue at the tail on a rising edge when st_valid=1, st_ready=1 and st_be!=0; a store with st_be=0 SHALL be discarded silently.
REQ-013 The block SHALL drop a store presented with st_valid=1, st_ready=0 and st_be!=0, and SHALL set ovf=1 until reset.
REQ-014 The block SHALL drive dm_we = reset & !empty & !dm_busy, combinationally.
REQ-015 The block SHALL drive dm_addr = {head.addr, 2'b00} and dm_be, dm_wd, dm_pc from the head entry; these SHALL be 0 when empty.
REQ-016 The block SHALL pop the head on the rising edge where dm_we=1: one entry per cycle, latency of at least 1 cycle from enqueue to dm_we.
REQ-017 The block SHALL, on a simultaneous push and pop, perform both and leave count unchanged.
REQ-018 The block SHALL wrap its head and tail pointers modulo DEPTH; full and empty SHALL be derived from count and never be ambiguous.
REQ-019 The block SHALL, per byte b, set ld_hit[b]=1 iff some valid entry has addr==ld_addr[31:2] and be[b]=1.
REQ-020 The block SHALL set ld_fwd_data byte b from the youngest such entry, and to 0 where ld_hit[b]=0.
REQ-021 The forwarding logic SHALL include the head entry even when it drains this cycle, and SHALL exclude the same-cycle st_* request.
REQ-022 The block SHALL ignore ld_addr[1:0] and st_addr[1:0]; byte selection SHALL be carried entirely by the byte enables.

Reset
REQ-023 The block SHALL, while reset=0 at a rising edge, clear count, head, tail and ovf, and discard all pending entries without writing them.
REQ-024 The block SHALL hold dm_we=0, st_ready=0 and ld_hit=0 for any cycle in which reset=0, including a reset applied mid-drain.
REQ-025 The block SHALL present empty=1, count=0 and all dm_* outputs = 0 in the first cycle after reset is released.

Structure
REQ-026 A shared package SHALL hold the DEPTH default, the entry field widths and the entry record layout.
REQ-027 The per-byte youngest-match priority selector SHALL be one sub-module, m_sb_fwd, instantiated four times (one per byte lane).

Verification
REQ-028 Scenario 1: push 0x10/be=F/0x11223344 with dm_busy=0 -> the next cycle shows dm_we=1, dm_addr=0x10, dm_wd=0x11223344; the cycle after shows empty=1.
REQ-029 Scenario 2: dm_busy=1, push 5 stores with DEPTH=4 -> st_ready=0 after the 4th store, the 5th store is dropped, ovf=1, count=4; then release dm_busy -> four writes in order, one per cycle.
REQ-030 Scenario 3: push 0x20/be=1/0x000000AA, then 0x20/be=3/0x0000BBCC, with dm_busy=1; ld_addr=0x23 -> ld_hit=0011, ld_fwd_data=0x0000BBCC.
REQ-031 Scenario 4: full buffer with dm_busy=0 and st_valid=1 -> the store is dropped (st_ready=0), one entry is popped, count=3; the next cycle accepts the store.
REQ-032 Scenario 5: 3 entries pending, reset=0 for one cycle -> dm_we=0 in that cycle and no DM write occurs; afterwards count=0, ovf=0.
REQ-033 Scenario 6: 40 push/drain cycles with random dm_busy -> the DM write sequence equals the accepted-store sequence, across at least two pointer wraps.
